// File: rtl/btn_pkg.sv
// Shared FSM state encoding, default parameters and a configuration range helper
// for the btn_debounce block.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CHK_PRESS = 2'd1,
        ST_HELD      = 2'd2,
        ST_CHK_REL   = 2'd3
    } btn_state_e;

    localparam int DEF_NB_BTN          = 4;
    localparam int DEF_NB_CNT          = 20;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_NB_RPT          = 26;
    localparam int DEF_REPEAT_CYCLES   = 50000000;

    // True when 1 <= value <= 2**width - 1, i.e. the value fits a width-bit counter.
    function automatic bit cfg_in_range(input longint value, input int width);
        return (value >= 1) && (value < (longint'(1) << width));
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM with saturating counter,
// registered press/release pulses. Optional auto-repeat under BTN_AUTOREPEAT_EN.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | level 0, waiting for the synchronized input to go high
// ST_CHK_PRESS | input high, counting stable cycles before accepting a press
// ST_HELD      | level 1, press accepted (auto-repeat timer runs here)
// ST_CHK_REL   | input low, counting stable cycles before accepting a release
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int NB_CNT          = DEF_NB_CNT,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int NB_RPT          = DEF_NB_RPT,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
)
(
    input  logic clock,
    input  logic i_reset,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    if (!cfg_in_range(longint'(DEBOUNCE_CYCLES), NB_CNT)) begin : g_bad_debounce
        $error("btn_debounce_ch: DEBOUNCE_CYCLES must be 1 .. 2**NB_CNT-1");
    end
    if (!cfg_in_range(longint'(REPEAT_CYCLES), NB_RPT)) begin : g_bad_repeat
        $error("btn_debounce_ch: REPEAT_CYCLES must be 1 .. 2**NB_RPT-1");
    end

    localparam logic [NB_CNT-1:0] CNT_TC  = NB_CNT'(DEBOUNCE_CYCLES);
    localparam logic [NB_CNT-1:0] CNT_ONE = NB_CNT'(1);

    logic [1:0]        sync_q;
    logic              s;
    btn_state_e        state_q, state_d;
    logic [NB_CNT-1:0] cnt_q, cnt_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              fsm_press;

    assign s = sync_q[1];

    always_ff @(posedge clock) begin
        if (i_reset) begin
            sync_q    <= 2'b00;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        fsm_press = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d = ST_CHK_PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_CHK_PRESS: begin
                if (!s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_TC) begin
                    state_d   = ST_HELD;
                    cnt_d     = '0;
                    level_d   = 1'b1;
                    fsm_press = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!s) begin
                    state_d = ST_CHK_REL;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_CHK_REL: begin
                if (s) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_TC) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [NB_RPT-1:0] RPT_TC  = NB_RPT'(REPEAT_CYCLES);
    localparam logic [NB_RPT-1:0] RPT_ONE = NB_RPT'(1);

    logic [NB_RPT-1:0] rpt_q, rpt_d;
    logic              rpt_pulse;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end

    // Any entry into HELD (press or bounce back from CHK_REL) restarts the period.
    always_comb begin
        rpt_d     = '0;
        rpt_pulse = 1'b0;
        if (state_d == ST_HELD) begin
            if (state_q != ST_HELD) begin
                rpt_d = RPT_ONE;
            end else if (rpt_q == RPT_TC) begin
                rpt_d     = RPT_ONE;
                rpt_pulse = 1'b1;
            end else begin
                rpt_d = rpt_q + RPT_ONE;
            end
        end
    end

    assign press_d = fsm_press | rpt_pulse;
`else
    assign press_d = fsm_press;
`endif

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/btn_debounce.sv
// NB_BTN independent debounced button channels with one-cycle press/release pulses.
// Auto-repeat of o_press while held is enabled by defining BTN_AUTOREPEAT_EN.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int NB_BTN          = DEF_NB_BTN,
    parameter int NB_CNT          = DEF_NB_CNT,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int NB_RPT          = DEF_NB_RPT,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
)
(
    input  logic              clock,
    input  logic              i_reset,
    input  logic [NB_BTN-1:0] i_btn,
    output logic [NB_BTN-1:0] o_level,
    output logic [NB_BTN-1:0] o_press,
    output logic [NB_BTN-1:0] o_release
);

    for (genvar g = 0; g < NB_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .NB_CNT          (NB_CNT),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .NB_RPT          (NB_RPT),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clock     (clock),
            .i_reset   (i_reset),
            .btn_i     (i_btn[g]),
            .level_o   (o_level[g]),
            .press_o   (o_press[g]),
            .release_o (o_release[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed scenarios plus randomized traffic,
// all compared against a run-length reference model of the debounce rules.
module tb_btn_debounce;

    localparam int NB_BTN = 4;
    localparam int NB_CNT = 20;
    localparam int DEB    = 4;
    localparam int NB_RPT = 26;
    localparam int RPT    = 10;

    logic              clock   = 1'b0;
    logic              i_reset = 1'b1;
    logic [NB_BTN-1:0] i_btn   = '0;
    logic [NB_BTN-1:0] o_level, o_press, o_release;

    int n_pass  = 0;
    int n_total = 0;

    btn_debounce #(
        .NB_BTN          (NB_BTN),
        .NB_CNT          (NB_CNT),
        .DEBOUNCE_CYCLES (DEB),
        .NB_RPT          (NB_RPT),
        .REPEAT_CYCLES   (RPT)
    ) dut (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_btn     (i_btn),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release)
    );

    always #5 clock = ~clock;

    // Reference model: the input seen by the debouncer is i_btn two edges late;
    // a new level is accepted once DEB+1 consecutive seen samples differ from it.
    logic [NB_BTN-1:0] m_p0 = '0, m_p1 = '0;
    logic [NB_BTN-1:0] m_level = '0, m_press = '0, m_release = '0;
    int                m_run [NB_BTN] = '{default: 0};
    logic [NB_BTN-1:0] nx_p0, nx_p1, nx_level, nx_press, nx_release;
    int                nx_run [NB_BTN];
`ifdef BTN_AUTOREPEAT_EN
    int                m_age [NB_BTN] = '{default: 0};
    int                nx_age [NB_BTN];
`endif

    always_comb begin
        nx_p0      = i_btn;
        nx_p1      = m_p0;
        nx_level   = m_level;
        nx_press   = '0;
        nx_release = '0;
        nx_run     = m_run;
`ifdef BTN_AUTOREPEAT_EN
        nx_age     = m_age;
`endif
        if (i_reset) begin
            nx_p0    = '0;
            nx_p1    = '0;
            nx_level = '0;
            for (int c = 0; c < NB_BTN; c++) begin
                nx_run[c] = 0;
`ifdef BTN_AUTOREPEAT_EN
                nx_age[c] = 0;
`endif
            end
        end else begin
            for (int c = 0; c < NB_BTN; c++) begin
                if (m_p1[c] != m_level[c]) begin
                    nx_run[c] = m_run[c] + 1;
`ifdef BTN_AUTOREPEAT_EN
                    nx_age[c] = 0;
`endif
                    if (nx_run[c] == DEB + 1) begin
                        nx_run[c]   = 0;
                        nx_level[c] = ~m_level[c];
                        if (nx_level[c]) nx_press[c] = 1'b1;
                        else             nx_release[c] = 1'b1;
                    end
                end else if (m_run[c] != 0) begin
                    nx_run[c] = 0;
`ifdef BTN_AUTOREPEAT_EN
                    nx_age[c] = 0;
`endif
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (m_level[c]) begin
                    nx_age[c] = m_age[c] + 1;
                    if (nx_age[c] == RPT) begin
                        nx_press[c] = 1'b1;
                        nx_age[c]   = 0;
                    end
                end
`endif
            end
        end
    end

    always @(posedge clock) begin
        m_p0      <= nx_p0;
        m_p1      <= nx_p1;
        m_level   <= nx_level;
        m_press   <= nx_press;
        m_release <= nx_release;
        m_run     <= nx_run;
`ifdef BTN_AUTOREPEAT_EN
        m_age     <= nx_age;
`endif
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        for (int n = 0; n < 4; n++) begin
            i_btn = 4'($urandom);
            tick();
            n_total++;
            if ({o_level, o_press, o_release} !== 12'h000)
                $display("FAIL reset_outputs got lvl=%b prs=%b rel=%b want all 0", o_level, o_press, o_release);
            else n_pass++;
        end
        i_btn   = '0;
        i_reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            n_total++;
            if ({o_level, o_press, o_release} !== 12'h000)
                $display("FAIL reset_idle got lvl=%b prs=%b rel=%b want all 0", o_level, o_press, o_release);
            else n_pass++;
        end
    endtask

    task automatic test_clean_press();
        int first = -1;
        int cnt   = 0;
        i_btn = 4'b0001;
        for (int n = 1; n <= 12; n++) begin
            tick();
            n_total++;
            if ({o_level, o_press, o_release} !== {m_level, m_press, m_release})
                $display("FAIL clean_model t=%0t got %b/%b/%b want %b/%b/%b", $time,
                         o_level, o_press, o_release, m_level, m_press, m_release);
            else n_pass++;
            if (o_press[0]) begin
                cnt++;
                if (first < 0) first = n;
            end
            if (n == 6) begin
                n_total++;
                if (o_level[0] !== 1'b0) $display("FAIL clean_level_early got %b want 0", o_level[0]);
                else n_pass++;
            end
        end
        n_total++;
        if (first != 7 || cnt != 1) $display("FAIL clean_press_timing got edge=%0d count=%0d want edge=7 count=1", first, cnt);
        else n_pass++;
        n_total++;
        if (o_level !== 4'b0001) $display("FAIL clean_level got %b want 0001", o_level);
        else n_pass++;
    endtask

    task automatic test_bounce();
        logic [3:0] seq = 4'b0101;
        int first = -1;
        int cnt   = 0;
        for (int i = 3; i >= 0; i--) begin
            i_btn[1] = seq[i] ^ 1'b1;
            tick();
            if (o_press[1]) cnt++;
        end
        i_btn[1] = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            n_total++;
            if ({o_level, o_press, o_release} !== {m_level, m_press, m_release})
                $display("FAIL bounce_model t=%0t got %b/%b/%b want %b/%b/%b", $time,
                         o_level, o_press, o_release, m_level, m_press, m_release);
            else n_pass++;
            if (o_press[1]) begin
                cnt++;
                if (first < 0) first = n;
            end
        end
        n_total++;
        if (first != 7 || cnt != 1) $display("FAIL bounce_press got edge=%0d count=%0d want edge=7 count=1", first, cnt);
        else n_pass++;
    endtask

    task automatic test_release_glitch();
        int first = -1;
        int cnt   = 0;
        i_btn[0] = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (n == 2) i_btn[0] = 1'b1;
            tick();
            n_total++;
            if ({o_level, o_press, o_release} !== {m_level, m_press, m_release})
                $display("FAIL glitch_model t=%0t got %b/%b/%b want %b/%b/%b", $time,
                         o_level, o_press, o_release, m_level, m_press, m_release);
            else n_pass++;
            if (o_release[0]) cnt++;
        end
        i_btn[0] = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            n_total++;
            if ({o_level, o_press, o_release} !== {m_level, m_press, m_release})
                $display("FAIL release_model t=%0t got %b/%b/%b want %b/%b/%b", $time,
                         o_level, o_press, o_release, m_level, m_press, m_release);
            else n_pass++;
            if (o_release[0]) begin
                cnt++;
                if (first < 0) first = n;
                n_total++;
                if (o_level[0] !== 1'b0) $display("FAIL release_level got %b want 0", o_level[0]);
                else n_pass++;
            end
        end
        n_total++;
        if (first != 7 || cnt != 1) $display("FAIL release_timing got edge=%0d count=%0d want edge=7 count=1", first, cnt);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int full = 0;
        int partial = 0;
        i_btn = 4'b0000;
        for (int n = 0; n < 10; n++) tick();
        n_total++;
        if (o_level !== 4'b0000) $display("FAIL simul_precond got %b want 0000", o_level);
        else n_pass++;
        i_btn = 4'b1111;
        for (int n = 1; n <= 12; n++) begin
            tick();
            n_total++;
            if ({o_level, o_press, o_release} !== {m_level, m_press, m_release})
                $display("FAIL simul_model t=%0t got %b/%b/%b want %b/%b/%b", $time,
                         o_level, o_press, o_release, m_level, m_press, m_release);
            else n_pass++;
            if (o_press == 4'b1111) full++;
            else if (o_press != 4'b0000) partial++;
        end
        n_total++;
        if (full != 1 || partial != 0) $display("FAIL simul_press got full=%0d partial=%0d want full=1 partial=0", full, partial);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int first = -1;
        int cnt   = 0;
        i_btn = 4'b0000;
        for (int n = 0; n < 10; n++) tick();
        i_btn = 4'b0100;
        for (int n = 0; n < 4; n++) tick();
        i_reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            n_total++;
            if ({o_level, o_press, o_release} !== 12'h000)
                $display("FAIL midreset_outputs got %b/%b/%b want all 0", o_level, o_press, o_release);
            else n_pass++;
        end
        i_reset = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            n_total++;
            if ({o_level, o_press, o_release} !== {m_level, m_press, m_release})
                $display("FAIL midreset_model t=%0t got %b/%b/%b want %b/%b/%b", $time,
                         o_level, o_press, o_release, m_level, m_press, m_release);
            else n_pass++;
            if (o_press[2]) begin
                cnt++;
                if (first < 0) first = n;
            end
        end
        n_total++;
        if (first != 7 || cnt != 1) $display("FAIL midreset_press got edge=%0d count=%0d want edge=7 count=1", first, cnt);
        else n_pass++;
    endtask

`ifdef BTN_AUTOREPEAT_EN
    task automatic test_autorepeat();
        logic [37:0] seen = '0;
        logic [37:0] want = '0;
        int found = 0;
        int presses = 0;
        int releases = 0;
        want[10] = 1'b1;
        want[20] = 1'b1;
        want[30] = 1'b1;
        i_btn = 4'b0000;
        for (int n = 0; n < 10; n++) tick();
        i_btn = 4'b1000;
        for (int n = 0; n < 12 && found == 0; n++) begin
            tick();
            if (o_press[3]) found = 1;
        end
        n_total++;
        if (found == 0) $display("FAIL repeat_first_press got none want one within 12 edges");
        else n_pass++;
        for (int n = 1; n <= 37; n++) begin
            tick();
            n_total++;
            if ({o_level, o_press, o_release} !== {m_level, m_press, m_release})
                $display("FAIL repeat_model t=%0t got %b/%b/%b want %b/%b/%b", $time,
                         o_level, o_press, o_release, m_level, m_press, m_release);
            else n_pass++;
            seen[n] = o_press[3];
        end
        n_total++;
        if (seen !== want) $display("FAIL repeat_offsets got %b want %b", seen, want);
        else n_pass++;
        i_btn = 4'b0000;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (o_press[3]) presses++;
            if (o_release[3]) releases++;
        end
        n_total++;
        if (presses != 0 || releases != 1) $display("FAIL repeat_release got press=%0d release=%0d want 0/1", presses, releases);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        int hold [NB_BTN] = '{default: 0};
        int bad = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NB_BTN; c++) begin
                if (hold[c] == 0) begin
                    i_btn[c] = ~i_btn[c];
                    hold[c]  = int'($urandom_range(1, 12));
                end else begin
                    hold[c]--;
                end
            end
            i_reset = ($urandom_range(0, 299) == 0);
            tick();
            n_total++;
            if ({o_level, o_press, o_release} !== {m_level, m_press, m_release}) begin
                if (bad < 10)
                    $display("FAIL random_model t=%0t got %b/%b/%b want %b/%b/%b", $time,
                             o_level, o_press, o_release, m_level, m_press, m_release);
                bad++;
            end else n_pass++;
        end
        i_reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_simultaneous();
        test_reset_mid();
`ifdef BTN_AUTOREPEAT_EN
        test_autorepeat();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Debounces and synchronizes NB_BTN raw push-button inputs and emits one-cycle press/release pulses. It drives the enable side of the LED blocks: each `o_press` bit feeds an `i_valid`-style enable, so one physical press toggles a LED exactly once. It sits between the board pins and the LED logic, in the same clock domain as the LEDs.

## Interface
- `NB_BTN`, 4, number of independent button channels
- `NB_CNT`, 20, width of the per-channel debounce counter
- `DEBOUNCE_CYCLES`, 1000000, consecutive stable cycles required to accept a new level; range 1 to 2^NB_CNT-1
- `NB_RPT`, 26, width of the per-channel repeat counter (used only with `BTN_AUTOREPEAT_EN`)
- `REPEAT_CYCLES`, 50000000, auto-repeat period in cycles; range 1 to 2^NB_RPT-1
- `clock`  in  1  system clock; all logic on the rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_btn`  in  NB_BTN  raw, asynchronous, bouncing button levels; 1 = pressed
- `o_level`  out  NB_BTN  debounced level per channel
- `o_press`  out  NB_BTN  one-cycle pulse per accepted press (and per repeat, if enabled)
- `o_release`  out  NB_BTN  one-cycle pulse per accepted release

## Operation
- Each bit of `i_btn` passes through a 2-flop synchronizer. All later logic uses only the synchronized bit `s`.
- Each channel runs an independent FSM with these states:
  - IDLE: level 0. If `s`=1, go to CHK_PRESS and set cnt=1.
  - CHK_PRESS: if `s`=0, return to IDLE and set cnt=0. Else if cnt==DEBOUNCE_CYCLES, go to HELD, set `o_level`=1 and pulse `o_press`. Else cnt+1.
  - HELD: level 1. If `s`=0, go to CHK_REL and set cnt=1.
  - CHK_REL: if `s`=1, return to HELD and set cnt=0. Else if cnt==DEBOUNCE_CYCLES, go to IDLE, set `o_level`=0 and pulse `o_release`. Else cnt+1.
- A glitch shorter than DEBOUNCE_CYCLES produces no output change.
- The counter never wraps: its maximum value is DEBOUNCE_CYCLES, which fits in NB_CNT.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- Pulses are registered outputs, high for exactly one cycle. `o_press` and `o_release` are never both high on the same channel.

## Timing
- Reset clears all outputs, synchronizer flops, counters and repeat counters to 0, and every FSM to IDLE.
- Reset asserted mid-count aborts the count and emits no pulse.
- A button held through reset release is debounced normally and produces one `o_press`.
- Latency: for a clean step on `i_btn` sampled at edge k, `o_level` changes and the pulse appears at edge k+2+DEBOUNCE_CYCLES.
- With DEBOUNCE_CYCLES=1, latency is 3 cycles.
- `o_level` changes in the same cycle that its pulse is high.

## Configuration
- Macro: `BTN_AUTOREPEAT_EN`.
- Defined: in HELD, a per-channel repeat counter increments each cycle. When it reaches REPEAT_CYCLES, `o_press` pulses again and the counter restarts at 1.
  - The first repeat comes REPEAT_CYCLES cycles after the initial press pulse.
  - Leaving HELD (including entering CHK_REL) clears the repeat counter.
  - A bounce that returns CHK_REL to HELD restarts the repeat count.
- Undefined: the repeat counter and its logic are not present. `o_press` pulses only once per accepted press.

## Structure
- Package `btn_pkg` holds the 2-bit FSM state encoding (IDLE=0, CHK_PRESS=1, HELD=2, CHK_REL=3) and the default parameter constants.
- Sub-module `btn_debounce_ch` implements one channel: synchronizer, FSM, counter and optional repeat logic.
- The top level generates NB_BTN instances of `btn_debounce_ch` and concatenates their outputs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=10.
- Clean press: `i_btn[0]` 0→1 sampled at edge k, held → `o_press[0]`=1 only at edge k+6, `o_level[0]`=1 from k+6. Other bits stay 0.
- Bounce: `i_btn[1]` toggles 1,0,1,0 on consecutive cycles, then held 1 → exactly one `o_press[1]`, 6 edges after the final rising sample. No pulse during the bounce.
- Release with glitch: held button drops for 2 cycles, returns high, then drops for good → no `o_release` for the glitch. One `o_release` 6 edges after the final falling sample, with `o_level` going to 0.
- Simultaneous: `i_btn` 4'b0000→4'b1111 at one edge → `o_press`=4'b1111 for exactly one cycle.
- Reset mid-operation: assert `i_reset` during CHK_PRESS at cnt=2, deassert with the button still high → no pulse during reset, all outputs 0. One `o_press` 6 edges after the first post-reset sample.
- With `BTN_AUTOREPEAT_EN`: hold for 40 cycles after the press → press pulses at +0, +10, +20, +30. Release → single `o_release`, no further presses.
